// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM observations into the controller, stall/flush/forward controls back out.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if;
    logic [4:0] RS1_ID;
    logic [4:0] RS2_ID;
    logic       USE_RS1_ID;
    logic       USE_RS2_ID;
    logic [4:0] RD_DE;
    logic       RegWrite_DE;
    logic [1:0] MemRead_DE;
    logic [4:0] RD_EM;
    logic       RegWrite_EM;
    // Handshake: DM_REQ stays high while the EX/MEM occupant waits; the access completes in the cycle DM_ACK=1.
    logic       DM_REQ;
    logic       DM_ACK;
    logic       BR_TAKEN_E;
    logic       STALL_F;
    logic       STALL_D;
    logic       STALL_E;
    logic       STALL_M;
    logic       FLUSH_D;
    logic       FLUSH_E;
    logic       BUBBLE_W;
    logic [1:0] FWD_A_DE;
    logic [1:0] FWD_B_DE;
    logic       DM_ERR;
    logic [1:0] STATE_DBG;

    modport master (
        output RS1_ID, RS2_ID, USE_RS1_ID, USE_RS2_ID,
        output RD_DE, RegWrite_DE, MemRead_DE, RD_EM, RegWrite_EM,
        output DM_REQ, DM_ACK, BR_TAKEN_E,
        input  STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E, BUBBLE_W,
        input  FWD_A_DE, FWD_B_DE, DM_ERR, STATE_DBG
    );

    modport slave (
        input  RS1_ID, RS2_ID, USE_RS1_ID, USE_RS2_ID,
        input  RD_DE, RegWrite_DE, MemRead_DE, RD_EM, RegWrite_EM,
        input  DM_REQ, DM_ACK, BR_TAKEN_E,
        output STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E, BUBBLE_W,
        output FWD_A_DE, FWD_B_DE, DM_ERR, STATE_DBG
    );
endinterface

// File: rtl/hazard_ctrl.sv
// RV32I 5-stage hazard controller: memory-wait stalls, branch flushes, load-use stalls, registered forward selects.
// Optional macro HAZ_FWD_EN enables forwarding; without it every RAW dependency on DE/EM is resolved by stalling.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input logic         CLK,
    input logic         RST,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT8 = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       dm_err_q;
    logic       mem_block;
    logic       stall_mem;
    logic       resolve;
    logic       dep_hit;
    logic       dep_stall;
    logic       flush_d;
    logic       flush_e;
    logic       de_match;

    assign mem_block = hz.DM_REQ && !hz.DM_ACK;

    assign de_match = hz.RegWrite_DE && (hz.RD_DE != 5'd0) &&
                      ((hz.USE_RS1_ID && (hz.RS1_ID == hz.RD_DE)) ||
                       (hz.USE_RS2_ID && (hz.RS2_ID == hz.RD_DE)));

`ifdef HAZ_FWD_EN
    // Only a load in ID/EX cannot be forwarded in time; ALU producers are covered by FWD_*_DE.
    assign dep_hit = de_match && (hz.MemRead_DE != 2'd0);
`else
    logic em_match;
    assign em_match = hz.RegWrite_EM && (hz.RD_EM != 5'd0) &&
                      ((hz.USE_RS1_ID && (hz.RS1_ID == hz.RD_EM)) ||
                       (hz.USE_RS2_ID && (hz.RS2_ID == hz.RD_EM)));
    assign dep_hit = de_match || em_match;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_RUN;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (mem_block) begin
                    cnt_d   = 8'd1;
                    state_d = (TIMEOUT8 <= 8'd1) ? S_ERR : S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (hz.DM_ACK) begin
                    cnt_d   = 8'd0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d >= TIMEOUT8) state_d = S_ERR;
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_RUN;
        endcase
    end

    // Outputs are gated by RST so an asynchronous reset clears them immediately.
    always_comb begin
        stall_mem = 1'b0;
        resolve   = 1'b0;
        if (!RST) begin
            case (state_q)
                S_RUN: begin
                    if (mem_block) stall_mem = 1'b1;
                    else           resolve   = 1'b1;
                end
                S_MEM_WAIT: begin
                    if (hz.DM_ACK) resolve   = 1'b1;
                    else           stall_mem = 1'b1;
                end
                default: stall_mem = 1'b1;
            endcase
        end
        flush_d   = resolve && hz.BR_TAKEN_E;
        dep_stall = resolve && !hz.BR_TAKEN_E && dep_hit;
        flush_e   = flush_d || dep_stall;
    end

    assign hz.STALL_F   = stall_mem || dep_stall;
    assign hz.STALL_D   = stall_mem || dep_stall;
    assign hz.STALL_E   = stall_mem;
    assign hz.STALL_M   = stall_mem;
    assign hz.FLUSH_D   = flush_d;
    assign hz.FLUSH_E   = flush_e;
    assign hz.BUBBLE_W  = stall_mem;
    assign hz.STATE_DBG = state_q;
    assign hz.DM_ERR    = dm_err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) dm_err_q <= 1'b0;
        else     dm_err_q <= dm_err_q || (state_d == S_ERR);
    end

`ifdef HAZ_FWD_EN
    logic [1:0] fwd_a_q, fwd_b_q;

    // MEM/WB producers need no select: the register file writes through to ID reads.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (hz.RegWrite_DE && (hz.RD_DE != 5'd0) && (hz.RD_DE == src) && (hz.MemRead_DE == 2'd0))
            return 2'b01;
        else if (hz.RegWrite_EM && (hz.RD_EM != 5'd0) && (hz.RD_EM == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else if (stall_mem) begin
            fwd_a_q <= fwd_a_q;
            fwd_b_q <= fwd_b_q;
        end else if (flush_e) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= fwd_sel(hz.RS1_ID);
            fwd_b_q <= fwd_sel(hz.RS2_ID);
        end
    end

    assign hz.FWD_A_DE = fwd_a_q;
    assign hz.FWD_B_DE = fwd_b_q;
`else
    assign hz.FWD_A_DE = 2'b00;
    assign hz.FWD_B_DE = 2'b00;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the RV32I 5-stage core. It watches the ID stage and the pipeline-register outputs (ID/EX, EX/MEM, MEM/WB) and drives back the stall, flush and forwarding controls that the forward-flowing pipeline latches consume. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits. It also registers EX-stage operand-forwarding selects alongside the ID/EX latch.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum DM_ACK wait cycles before error (range 1..255).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- RS1_ID, RS2_ID  in  5  source registers of the instruction in ID.
- USE_RS1_ID, USE_RS2_ID  in  1  the ID instruction actually reads rs1/rs2.
- RD_DE  in  5  destination register of the ID/EX occupant.
- RegWrite_DE  in  1  ID/EX occupant writes a register.
- MemRead_DE  in  2  nonzero means the ID/EX occupant is a load.
- RD_EM  in  5  destination register of the EX/MEM occupant.
- RegWrite_EM  in  1  EX/MEM occupant writes a register.
- DM_REQ  in  1  the EX/MEM occupant performs a memory access (MemRead_EM or MemWrite_EM nonzero).
- DM_ACK  in  1  data memory completes the access this cycle.
- BR_TAKEN_E  in  1  the branch or jump in EX is taken.
- STALL_F, STALL_D  out  1  hold PC and IF/ID.
- STALL_E, STALL_M  out  1  hold ID/EX and EX/MEM.
- FLUSH_D  out  1  load NOP into IF/ID.
- FLUSH_E  out  1  load bubble into ID/EX (all control fields 0).
- BUBBLE_W  out  1  load bubble into MEM/WB (RegWrite_MW=0).
- FWD_A_DE, FWD_B_DE  out  2  registered EX operand select: 00 = register file, 01 = EX/MEM ALU value, 10 = MEM/WB writeback value.
- DM_ERR  out  1  memory timeout, sticky.

## Operation
- FSM states:
  - RUN: hazard resolution as below.
  - MEM_WAIT: DM_REQ pending without DM_ACK.
  - ERR: memory timeout occurred.
- RUN → MEM_WAIT when DM_REQ=1 and DM_ACK=0. In the same cycle STALL_F/D/E/M=1, BUBBLE_W=1, and the wait counter is loaded with 1.
- MEM_WAIT, DM_ACK=1: all stalls drop this cycle and BUBBLE_W=0 (the access completes into MEM/WB). Next state is RUN.
- MEM_WAIT, DM_ACK=0: stalls and BUBBLE_W stay at 1 and the counter increments. When the counter reaches MEM_TIMEOUT, next state is ERR.
- ERR: all stalls=1, BUBBLE_W=1, DM_ERR=1. Leaves only on RST.
- Priority is memory wait > taken branch > load-use.
  - A BR_TAKEN_E arriving during MEM_WAIT is held in EX by STALL_E and acts in the release cycle.
- Taken branch (RUN, no memory stall): FLUSH_D=1 and FLUSH_E=1 in the same cycle. The load-use stall is suppressed.
- Load-use: condition is MemRead_DE≠0, RegWrite_DE=1, RD_DE≠0, and (USE_RS1_ID and RS1_ID==RD_DE, or USE_RS2_ID and RS2_ID==RD_DE). Response is STALL_F=STALL_D=1 and FLUSH_E=1 for exactly one cycle.
- Forward selects are computed from ID-stage sources and registered on the edge that loads ID/EX:
  - 01 if RegWrite_DE, RD_DE≠0, RD_DE==src, and the producer is not a load.
  - Otherwise 10 if RegWrite_EM, RD_EM≠0, and RD_EM==src.
  - Otherwise 00.
  - 01 has priority over 10.
  - A producer in MEM/WB at ID time is covered by register-file write-through and needs no forward.
- FWD_*_DE hold when STALL_E=1 and clear to 00 when FLUSH_E=1, with STALL_E winning.

## Timing
- Reset values: all stalls, flushes and BUBBLE_W are 0; FWD_A_DE=FWD_B_DE=00; DM_ERR=0; state is RUN; counter is 0.
  - Asynchronous assertion; synchronous-release use only.
- Stall, flush and bubble outputs are combinational from the current state and inputs, with zero latency.
- FWD_*_DE have 1-cycle latency and align with the ID/EX contents.
- DM_ACK in the same cycle as DM_REQ rises: no stall, no state change.
- RST during MEM_WAIT or ERR: immediately RUN, outputs at reset values, counter cleared.
- DM_ERR is registered and rises on the cycle after the counter hits MEM_TIMEOUT.

## Configuration
- HAZ_FWD_EN defined: forwarding as above.
- HAZ_FWD_EN undefined:
  - FWD_*_DE are tied to 00.
  - Any RegWrite producer in DE or EM with nonzero rd matching a used source causes STALL_F=STALL_D=1 and FLUSH_E=1, repeating until no match remains (up to 2 cycles).
  - The load-use rule is subsumed by this.

## Test plan
- Forward from EX/MEM: `add x5` in DE, `sub` reading rs1=x5 in ID → next cycle FWD_A_DE=01, FWD_B_DE=00, no stall.
- Load-use stall: `lw x7` in DE, ID reads rs2=x7 → one cycle of STALL_F=STALL_D=FLUSH_E=1, then FWD_B_DE=10 when the consumer enters EX. A second case with rd=x0 must produce no stall.
- Taken branch: BR_TAKEN_E=1 with a load-use condition also present → FLUSH_D=FLUSH_E=1, STALL_F=0.
- Memory wait: DM_REQ=1, DM_ACK low for 3 cycles → 3 cycles of all stalls plus BUBBLE_W=1; on the ack cycle everything is 0; branch pending during the wait flushes in the ack cycle.
- Timeout: MEM_TIMEOUT=4, DM_ACK never arrives → DM_ERR=1 after the counter hits 4, all stalls held; RST mid-ERR clears all outputs asynchronously.
- HAZ_FWD_EN undefined: `add x3` in DE, ID reads x3 → 2 stall cycles, FWD_*_DE=00 throughout.
